// File: rtl/pack_gen_stream.sv
// pack_gen_stream: per-port packet generator that expands queued metadata entries into framed word streams.
// Optional build macro PACK_GEN_SEQ_EN: payload words carry {pkt_cnt, word index} instead of all ones.
module pack_gen_stream #(
    parameter int  PORT_CNT   = 4,
    parameter int  META_DEPTH = 1024,
    parameter int  BLOCK_SIZE = 32,
    parameter int  WORD_WIDTH = 32,
    parameter int  LEN_WIDTH  = 12,
    parameter int  MAX_BLOCKS = 64,
    parameter int  META_WIDTH = 16,
    localparam int PORT_BITS  = $clog2(PORT_CNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORT_BITS-1:0]  src_port,
    input  logic                  meta_en,
    input  logic [META_WIDTH-1:0] meta_in,
    output logic                  meta_full,
    input  logic                  pkt_ready,
    output logic                  pkt_valid,
    output logic [WORD_WIDTH-1:0] pkt_data,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic                  busy,
    output logic                  overflow,
    output logic                  bad_len,
    output logic [15:0]           pkt_cnt
);

    localparam int WPB       = BLOCK_SIZE * 8 / WORD_WIDTH;
    localparam int PTR_W     = $clog2(META_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int IDX_W     = $clog2(MAX_BLOCKS * WPB);
    localparam int HDR_WORDS = 6;
    localparam logic [39:0] MAC_OUI = 40'h02_00_00_00_00;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HDR,
        PAYLOAD
    } state_t;

    state_t                state;
    logic [META_WIDTH-1:0] mem [META_DEPTH];
    logic [META_WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [63:0]           ts;
    logic                  wr_accept;
    logic                  rd_en;
    logic                  accept;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [PORT_BITS-1:0]  dest_q;
    logic                  len_ok;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [PORT_BITS-1:0]  dest_r;
    logic [63:0]           ts_r;
    logic [IDX_W-1:0]      word_idx;
    logic [IDX_W-1:0]      next_idx;
    logic [IDX_W-1:0]      last_idx;
    logic                  unused_q;

    assign meta_full = (count == CNT_W'(META_DEPTH));
    assign wr_accept = meta_en && !meta_full;
    assign rd_en     = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);
    assign accept    = pkt_valid && pkt_ready;
    assign next_idx  = word_idx + IDX_W'(1);

    assign len_q    = mem_q[LEN_WIDTH-1:0];
    assign dest_q   = mem_q[LEN_WIDTH+PORT_BITS-1:LEN_WIDTH];
    assign len_ok   = (len_q != '0) && (len_q <= LEN_WIDTH'(MAX_BLOCKS));
    assign unused_q = ^mem_q;

    // Word at index idx of a packet; header words are 32 bits zero-extended to WORD_WIDTH.
    function automatic logic [WORD_WIDTH-1:0] make_word(
        input logic [LEN_WIDTH-1:0] len,
        input logic [PORT_BITS-1:0] dst,
        input logic [63:0]          tsv,
        input logic [IDX_W-1:0]     idx
    );
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [31:0] w;
        dmac = {MAC_OUI, 8'(dst)};
        smac = {MAC_OUI, 8'(src_port)};
        case (idx)
            IDX_W'(0): w = {16'(len * BLOCK_SIZE), dmac[47:32]};
            IDX_W'(1): w = dmac[31:0];
            IDX_W'(2): w = tsv[63:32];
            IDX_W'(3): w = tsv[31:0];
            IDX_W'(4): w = smac[47:16];
            IDX_W'(5): w = {smac[15:0], 16'h0000};
            default:   w = '0;
        endcase
        if (idx < IDX_W'(HDR_WORDS)) begin
            return WORD_WIDTH'(w);
        end
`ifdef PACK_GEN_SEQ_EN
        return WORD_WIDTH'({pkt_cnt, 16'(idx)});
`else
        return '1;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= meta_in;
        end
        if (rd_en) begin
            mem_q <= mem[rd_ptr];
        end
    end

    // A write while full is dropped even if a read frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ts       <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + 64'd1;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_accept) - CNT_W'(rd_en);
            if (meta_en && meta_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pkt_valid <= 1'b0;
            pkt_sop   <= 1'b0;
            pkt_eop   <= 1'b0;
            pkt_data  <= '0;
            pkt_cnt   <= '0;
            bad_len   <= 1'b0;
            len_r     <= '0;
            dest_r    <= '0;
            ts_r      <= '0;
            word_idx  <= '0;
            last_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!len_ok) begin
                        bad_len <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        len_r     <= len_q;
                        dest_r    <= dest_q;
                        ts_r      <= ts;
                        word_idx  <= '0;
                        last_idx  <= IDX_W'(len_q * WPB - 1);
                        pkt_valid <= 1'b1;
                        pkt_sop   <= 1'b1;
                        pkt_eop   <= 1'b0;
                        pkt_data  <= make_word(len_q, dest_q, ts, '0);
                        state     <= HDR;
                    end
                end
                HDR, PAYLOAD: begin
                    if (accept) begin
                        if (pkt_eop) begin
                            pkt_valid <= 1'b0;
                            pkt_sop   <= 1'b0;
                            pkt_eop   <= 1'b0;
                            pkt_cnt   <= pkt_cnt + 16'd1;
                            state     <= IDLE;
                        end else begin
                            word_idx <= next_idx;
                            pkt_data <= make_word(len_r, dest_r, ts_r, next_idx);
                            pkt_sop  <= 1'b0;
                            pkt_eop  <= (next_idx == last_idx);
                            if (state == HDR && next_idx == IDX_W'(HDR_WORDS)) begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pack_gen_stream.sv
// tb_pack_gen_stream: randomized and directed stimulus checked against a queue-based packet model.
module tb_pack_gen_stream;

    localparam int WPB = 8;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [1:0]  src_port  = 2'd1;
    logic        meta_en   = 1'b0;
    logic [15:0] meta_in   = '0;
    logic        pkt_ready = 1'b1;
    logic        meta_full;
    logic        pkt_valid;
    logic [31:0] pkt_data;
    logic        pkt_sop;
    logic        pkt_eop;
    logic        busy;
    logic        overflow;
    logic        bad_len;
    logic [15:0] pkt_cnt;

    typedef struct {
        int dest;
        int len;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] acc[$];
    int          total = 0;
    int          bad = 0;
    int          m_cnt = 0;
    bit          m_bad = 0;
    bit          in_pkt = 0;
    bit          held = 0;
    logic [33:0] h_word = '0;
    ent_t        cur;
    int          idx = 0;
    int          last = 0;
    logic [63:0] cur_ts = '0;
    logic [63:0] tb_ts = '0;
    int          rdy_mode = 0;

    always #5 clk = ~clk;

    pack_gen_stream #(
        .PORT_CNT(4),
        .META_DEPTH(1024),
        .BLOCK_SIZE(32),
        .WORD_WIDTH(32),
        .LEN_WIDTH(12),
        .MAX_BLOCKS(64),
        .META_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src_port(src_port),
        .meta_en(meta_en),
        .meta_in(meta_in),
        .meta_full(meta_full),
        .pkt_ready(pkt_ready),
        .pkt_valid(pkt_valid),
        .pkt_data(pkt_data),
        .pkt_sop(pkt_sop),
        .pkt_eop(pkt_eop),
        .busy(busy),
        .overflow(overflow),
        .bad_len(bad_len),
        .pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Packet image: a flat 192-bit header followed by payload words.
    function automatic logic [31:0] exp_word(input ent_t e, input int i, input logic [63:0] t);
        logic [47:0]  dmac;
        logic [47:0]  smac;
        logic [191:0] hdr;
        dmac = {40'h02_0000_0000, 8'(e.dest)};
        smac = {40'h02_0000_0000, 8'(src_port)};
        hdr  = {16'(e.len * 32), dmac, t, smac, 16'h0000};
        if (i < 6) return hdr[191 - 32*i -: 32];
`ifdef PACK_GEN_SEQ_EN
        return {m_cnt[15:0], 16'(i)};
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) tb_ts = '0;
            else       tb_ts = tb_ts + 64'd1;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       pkt_ready = 1'b1;
                1:       pkt_ready = 1'($urandom_range(0, 1));
                default: pkt_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_pkt = 0;
                held   = 0;
                m_cnt  = 0;
                m_bad  = 0;
            end else begin
                chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt[15:0]));
                if (held) begin
                    chk("hold_valid", 64'(pkt_valid), 64'(1));
                    chk("hold_word", 64'({pkt_sop, pkt_eop, pkt_data}), 64'(h_word));
                end
                if (pkt_valid && !in_pkt) begin
                    while (mq.size() > 0 && (mq[0].len == 0 || mq[0].len > 64)) begin
                        void'(mq.pop_front());
                        m_bad = 1;
                    end
                    if (mq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got valid with data %0h want no packet", pkt_data);
                    end else begin
                        cur    = mq.pop_front();
                        in_pkt = 1;
                        idx    = 0;
                        cur_ts = tb_ts - 64'd1;
                    end
                end
                if (pkt_valid && in_pkt) begin
                    last = cur.len * WPB - 1;
                    chk("word", 64'(pkt_data), 64'(exp_word(cur, idx, cur_ts)));
                    chk("sop", 64'(pkt_sop), 64'(idx == 0));
                    chk("eop", 64'(pkt_eop), 64'(idx == last));
                    if (pkt_ready) begin
                        acc.push_back(pkt_data);
                        if (idx == last) begin
                            in_pkt = 0;
                            m_cnt++;
                        end else begin
                            idx++;
                        end
                    end
                end
                held   = pkt_valid && !pkt_ready;
                h_word = {pkt_sop, pkt_eop, pkt_data};
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_meta(input int d, input int l, input bit push);
        ent_t e;
        meta_en        = 1'b1;
        meta_in        = '0;
        meta_in[11:0]  = l[11:0];
        meta_in[13:12] = d[1:0];
        e.dest = d;
        e.len  = l;
        if (push) mq.push_back(e);
        step(1);
        meta_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!pkt_valid && n < 300) begin
            step(1);
            n++;
        end
        chk(nm, 64'(pkt_valid), 64'(1));
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (!(mq.size() == 0 && !in_pkt && !busy) && n < budget) begin
            step(1);
            n++;
        end
        chk(nm, 64'(mq.size() == 0 && !in_pkt && !busy), 64'(1));
    endtask

    logic [31:0] exp_w6;
    logic [31:0] exp_w7;
    logic [31:0] exp_seq;

    initial begin
`ifdef PACK_GEN_SEQ_EN
        exp_w6  = 32'h0000_0006;
        exp_w7  = 32'h0000_0007;
        exp_seq = 32'h0001_0006;
`else
        exp_w6  = 32'hFFFF_FFFF;
        exp_w7  = 32'hFFFF_FFFF;
        exp_seq = 32'hFFFF_FFFF;
`endif
        do_reset();

        chk("rst_valid", 64'(pkt_valid), 64'(0));
        chk("rst_sop", 64'(pkt_sop), 64'(0));
        chk("rst_eop", 64'(pkt_eop), 64'(0));
        chk("rst_data", 64'(pkt_data), 64'(0));
        chk("rst_full", 64'(meta_full), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_bad_len", 64'(bad_len), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));

        // Single L=1 packet: latency and literal header words.
        acc.delete();
        write_meta(2, 1, 1);
        chk("lat_n0_valid", 64'(pkt_valid), 64'(0));
        step(1);
        chk("lat_n1_valid", 64'(pkt_valid), 64'(0));
        step(1);
        chk("lat_n2_valid", 64'(pkt_valid), 64'(1));
        chk("lat_n2_sop", 64'(pkt_sop), 64'(1));
        chk("lat_n2_w0", 64'(pkt_data), 64'(32'h0020_0200));
        wait_idle("drain_l1", 200);
        chk("l1_words", 64'(acc.size()), 64'(8));
        if (acc.size() == 8) begin
            chk("l1_w1", 64'(acc[1]), 64'(32'h0000_0002));
            chk("l1_w2", 64'(acc[2]), 64'(32'h0000_0000));
            chk("l1_w4", 64'(acc[4]), 64'(32'h0200_0000));
            chk("l1_w5", 64'(acc[5]), 64'(32'h0001_0000));
            chk("l1_w6", 64'(acc[6]), 64'(exp_w6));
            chk("l1_w7", 64'(acc[7]), 64'(exp_w7));
        end
        chk("l1_pkt_cnt", 64'(pkt_cnt), 64'(1));

        // Max-length packet under random backpressure.
        rdy_mode = 1;
        acc.delete();
        write_meta(2, 64, 1);
        wait_valid("l64_start");
        chk("l64_w0_len", 64'(pkt_data[31:16]), 64'(16'h0800));
        wait_idle("drain_l64", 3000);
        chk("l64_words", 64'(acc.size()), 64'(512));

        // Random traffic, occasional illegal lengths.
        for (int i = 0; i < 20; i++) begin
            int r;
            int l;
            r = $urandom_range(0, 9);
            if (r == 0) l = ($urandom_range(0, 1) == 1) ? 0 : 65 + $urandom_range(0, 100);
            else        l = $urandom_range(1, 16);
            write_meta($urandom_range(0, 3), l, 1);
            step($urandom_range(0, 30));
        end
        write_meta($urandom_range(0, 3), $urandom_range(1, 8), 1);
        wait_idle("drain_rand", 20000);
        chk("rand_bad_len", 64'(bad_len), 64'(m_bad));

        // Fill the queue behind a stalled packet, then overflow it.
        rdy_mode = 2;
        step(2);
        write_meta(0, 1, 1);
        wait_valid("ovf_stall");
        for (int i = 0; i < 1023; i++) write_meta(i % 4, 1, 1);
        chk("ovf_full_1023", 64'(meta_full), 64'(0));
        write_meta(1, 1, 1);
        chk("ovf_full_1024", 64'(meta_full), 64'(1));
        chk("ovf_before", 64'(overflow), 64'(0));
        write_meta(3, 7, 0);
        chk("ovf_after", 64'(overflow), 64'(1));
        chk("ovf_still_full", 64'(meta_full), 64'(1));
        rdy_mode = 0;
        wait_idle("drain_ovf", 20000);

        // Illegal lengths are discarded silently apart from bad_len.
        do_reset();
        acc.delete();
        chk("bl_clear", 64'(bad_len), 64'(0));
        write_meta(1, 0, 1);
        write_meta(2, 65, 1);
        write_meta(3, 2, 1);
        wait_idle("drain_bl", 500);
        chk("bl_set", 64'(bad_len), 64'(1));
        chk("bl_pkt_cnt", 64'(pkt_cnt), 64'(1));
        chk("bl_words", 64'(acc.size()), 64'(16));

        // Reset in the middle of a packet.
        write_meta(1, 4, 1);
        write_meta(2, 1, 1);
        wait_valid("mid_start");
        step(3);
        chk("mid_w3_valid", 64'(pkt_valid), 64'(1));
        chk("mid_w3_eop", 64'(pkt_eop), 64'(0));
        reset = 1'b1;
        mq.delete();
        step(1);
        reset = 1'b0;
        chk("mid_valid", 64'(pkt_valid), 64'(0));
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_pkt_cnt", 64'(pkt_cnt), 64'(0));
        write_meta(0, 1, 1);
        wait_valid("mid_restart");
        chk("mid_restart_sop", 64'(pkt_sop), 64'(1));
        wait_idle("drain_mid", 300);

        // Payload of the second packet after reset.
        do_reset();
        acc.delete();
        write_meta(1, 1, 1);
        write_meta(2, 1, 1);
        wait_idle("drain_seq", 300);
        chk("seq_words", 64'(acc.size()), 64'(16));
        if (acc.size() == 16) chk("seq_w6", 64'(acc[14]), 64'(exp_seq));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
